// File: rtl/io_tape_device.sv
// Device-side paper-tape reader and punch with host-loadable FIFOs.
// Define IO_TAPE_PACE_EN to hold each GAP state for PACE_CYCLES cycles.
module io_tape_device #(
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned PACE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               input_rdy_from_io,
  output logic               input_val_to_io,
  output logic [4:0]         input_data_to_io,
  input  logic               output_rdy_from_io,
  input  logic [4:0]         output_data_from_io,
  output logic               output_ack_to_io,
  input  logic               tape_in_valid,
  input  logic [4:0]         tape_in_data,
  output logic               tape_in_ready,
  output logic               punch_out_valid,
  output logic [4:0]         punch_out_data,
  input  logic               punch_out_ready,
  output logic [FIFO_AW:0]   reader_count,
  output logic [FIFO_AW:0]   punch_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  if (PACE_CYCLES < 1) begin : g_bad_pace
    $error("PACE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {RD_IDLE, RD_VAL, RD_GAP} rd_state_e;
  typedef enum logic [1:0] {PU_IDLE, PU_ACK, PU_GAP} pu_state_e;

  logic [4:0]         rd_mem_q [DEPTH];
  logic [FIFO_AW-1:0] rd_wptr_q, rd_rptr_q;
  logic [FIFO_AW:0]   rd_cnt_q;
  logic               rd_full_c, rd_empty_c, rd_push_c, rd_pop_c;

  logic [4:0]         pu_mem_q [DEPTH];
  logic [FIFO_AW-1:0] pu_wptr_q, pu_rptr_q;
  logic [FIFO_AW:0]   pu_cnt_q;
  logic               pu_full_c, pu_empty_c, pu_push_c, pu_pop_c;

  rd_state_e rd_state_q, rd_state_d;
  pu_state_e pu_state_q, pu_state_d;
  logic      input_val_q, output_ack_q;
  logic      rd_gap_done_c, pu_gap_done_c;

  assign rd_full_c  = (rd_cnt_q == CW'(DEPTH));
  assign rd_empty_c = (rd_cnt_q == '0);
  assign rd_push_c  = tape_in_valid && !rd_full_c;
  assign pu_full_c  = (pu_cnt_q == CW'(DEPTH));
  assign pu_empty_c = (pu_cnt_q == '0);
  assign pu_pop_c   = punch_out_ready && !pu_empty_c;

  // Storage arrays carry no reset; an empty FIFO presents zero at its head.
  always_ff @(posedge clk) begin
    if (rd_push_c) rd_mem_q[rd_wptr_q] <= tape_in_data;
    if (pu_push_c) pu_mem_q[pu_wptr_q] <= output_data_from_io;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_wptr_q <= '0;
      rd_rptr_q <= '0;
      rd_cnt_q  <= '0;
      pu_wptr_q <= '0;
      pu_rptr_q <= '0;
      pu_cnt_q  <= '0;
    end else begin
      if (rd_push_c) rd_wptr_q <= rd_wptr_q + FIFO_AW'(1);
      if (rd_pop_c)  rd_rptr_q <= rd_rptr_q + FIFO_AW'(1);
      if (rd_push_c && !rd_pop_c)      rd_cnt_q <= rd_cnt_q + CW'(1);
      else if (!rd_push_c && rd_pop_c) rd_cnt_q <= rd_cnt_q - CW'(1);
      if (pu_push_c) pu_wptr_q <= pu_wptr_q + FIFO_AW'(1);
      if (pu_pop_c)  pu_rptr_q <= pu_rptr_q + FIFO_AW'(1);
      if (pu_push_c && !pu_pop_c)      pu_cnt_q <= pu_cnt_q + CW'(1);
      else if (!pu_push_c && pu_pop_c) pu_cnt_q <= pu_cnt_q - CW'(1);
    end
  end

  // Reader: pop only when the I/O unit releases rdy, so data holds while val is high.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_pop_c   = 1'b0;
    unique case (rd_state_q)
      RD_IDLE: if (input_rdy_from_io && !rd_empty_c) rd_state_d = RD_VAL;
      RD_VAL: begin
        if (!input_rdy_from_io) begin
          rd_state_d = RD_GAP;
          rd_pop_c   = 1'b1;
        end
      end
      RD_GAP:  if (rd_gap_done_c) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Punch: capture the offered code on the same edge ack is raised.
  always_comb begin
    pu_state_d = pu_state_q;
    pu_push_c  = 1'b0;
    unique case (pu_state_q)
      PU_IDLE: begin
        if (output_rdy_from_io && !pu_full_c) begin
          pu_state_d = PU_ACK;
          pu_push_c  = 1'b1;
        end
      end
      PU_ACK:  if (!output_rdy_from_io) pu_state_d = PU_GAP;
      PU_GAP:  if (pu_gap_done_c) pu_state_d = PU_IDLE;
      default: pu_state_d = PU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q   <= RD_IDLE;
      pu_state_q   <= PU_IDLE;
      input_val_q  <= 1'b0;
      output_ack_q <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      pu_state_q   <= pu_state_d;
      input_val_q  <= (rd_state_d == RD_VAL);
      output_ack_q <= (pu_state_d == PU_ACK);
    end
  end

`ifdef IO_TAPE_PACE_EN
  localparam int unsigned PW = $clog2(PACE_CYCLES + 1);

  logic [PW-1:0] rd_pace_q, rd_pace_d, pu_pace_q, pu_pace_d;

  // Down-counters loaded on GAP entry; GAP exits on the cycle they read zero.
  always_comb begin
    rd_pace_d = rd_pace_q;
    pu_pace_d = pu_pace_q;
    if (rd_state_q == RD_VAL && rd_state_d == RD_GAP)
      rd_pace_d = PW'(PACE_CYCLES - 1);
    else if (rd_state_q == RD_GAP && rd_pace_q != '0)
      rd_pace_d = rd_pace_q - PW'(1);
    if (pu_state_q == PU_ACK && pu_state_d == PU_GAP)
      pu_pace_d = PW'(PACE_CYCLES - 1);
    else if (pu_state_q == PU_GAP && pu_pace_q != '0)
      pu_pace_d = pu_pace_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pace_q <= '0;
      pu_pace_q <= '0;
    end else begin
      rd_pace_q <= rd_pace_d;
      pu_pace_q <= pu_pace_d;
    end
  end

  assign rd_gap_done_c = (rd_pace_q == '0);
  assign pu_gap_done_c = (pu_pace_q == '0);
`else
  assign rd_gap_done_c = 1'b1;
  assign pu_gap_done_c = 1'b1;
`endif

  assign input_val_to_io  = input_val_q;
  assign output_ack_to_io = output_ack_q;
  assign input_data_to_io = rd_empty_c ? 5'b0 : rd_mem_q[rd_rptr_q];
  assign punch_out_data   = pu_empty_c ? 5'b0 : pu_mem_q[pu_rptr_q];
  assign tape_in_ready    = !rd_full_c;
  assign punch_out_valid  = !pu_empty_c;
  assign reader_count     = rd_cnt_q;
  assign punch_count      = pu_cnt_q;

endmodule

// File: tb/tb_io_tape_device.sv
// Directed bench for io_tape_device: reader/punch handshakes, FIFO limits, reset.
module tb_io_tape_device;

  logic       clk;
  logic       resetn;
  logic       in_rdy, in_val;
  logic [4:0] in_data;
  logic       out_rdy, out_ack;
  logic [4:0] out_data;
  logic       tin_valid, tin_ready;
  logic [4:0] tin_data;
  logic       pout_valid, pout_ready;
  logic [4:0] pout_data;
  logic [4:0] rcount, pcount;

  int n_checks = 0;
  int n_pass   = 0;

  io_tape_device #(.FIFO_AW(4), .PACE_CYCLES(8)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .input_rdy_from_io   (in_rdy),
    .input_val_to_io     (in_val),
    .input_data_to_io    (in_data),
    .output_rdy_from_io  (out_rdy),
    .output_data_from_io (out_data),
    .output_ack_to_io    (out_ack),
    .tape_in_valid       (tin_valid),
    .tape_in_data        (tin_data),
    .tape_in_ready       (tin_ready),
    .punch_out_valid     (pout_valid),
    .punch_out_data      (pout_data),
    .punch_out_ready     (pout_ready),
    .reader_count        (rcount),
    .punch_count         (pcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_reader(input logic [4:0] code);
    tin_valid = 1'b1;
    tin_data  = code;
    tick();
    tin_valid = 1'b0;
  endtask

  task automatic offer_punch(input logic [4:0] code);
    out_data = code;
    out_rdy  = 1'b1;
    tick();
    check("pu_ack_rise", 32'(out_ack), 32'd1);
    out_rdy = 1'b0;
    tick();
    check("pu_ack_fall", 32'(out_ack), 32'd0);
    idle(12);
  endtask

  int  n;
  int  expected_gap;
  bit  seen;

  initial begin
    resetn = 1'b0; in_rdy = 1'b0; out_rdy = 1'b0; out_data = '0;
    tin_valid = 1'b0; tin_data = '0; pout_ready = 1'b0;
    idle(2);
    check("rst_val",    32'(in_val),     32'd0);
    check("rst_ack",    32'(out_ack),    32'd0);
    check("rst_pvalid", 32'(pout_valid), 32'd0);
    check("rst_tready", 32'(tin_ready),  32'd1);
    check("rst_rcount", 32'(rcount),     32'd0);
    check("rst_pcount", 32'(pcount),     32'd0);
    check("rst_idata",  32'(in_data),    32'd0);
    check("rst_pdata",  32'(pout_data),  32'd0);
    resetn = 1'b1;
    tick();

    // Two reader characters, one rdy pulse each
    push_reader(5'b10011);
    push_reader(5'b00110);
    check("rd_count2", 32'(rcount), 32'd2);
    check("rd_head1",  32'(in_data), 32'b10011);
    in_rdy = 1'b1;
    tick();
    check("rd_val1_rise", 32'(in_val),  32'd1);
    check("rd_data1",     32'(in_data), 32'b10011);
    in_rdy = 1'b0;
    tick();
    check("rd_val1_fall", 32'(in_val),  32'd0);
    check("rd_count1",    32'(rcount),  32'd1);
    check("rd_head2",     32'(in_data), 32'b00110);
    idle(12);
    in_rdy = 1'b1;
    tick();
    check("rd_val2_rise", 32'(in_val),  32'd1);
    check("rd_data2",     32'(in_data), 32'b00110);
    in_rdy = 1'b0;
    tick();
    check("rd_val2_fall", 32'(in_val), 32'd0);
    check("rd_count0",    32'(rcount), 32'd0);
    idle(12);

    // rdy held with empty reader FIFO
    in_rdy = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (in_val) seen = 1'b1;
    end
    check("rd_empty_wait", 32'(seen), 32'd0);
    push_reader(5'b00111);
    check("rd_push_plus1", 32'(in_val), 32'd0);
    tick();
    check("rd_push_plus2", 32'(in_val),  32'd1);
    check("rd_push_data",  32'(in_data), 32'b00111);
    in_rdy = 1'b0;
    tick();
    idle(12);

    // Back-to-back characters: gap between val fall and next val rise
    push_reader(5'b00001);
    push_reader(5'b00010);
    in_rdy = 1'b1;
    tick();
    check("gap_val_a", 32'(in_val), 32'd1);
    in_rdy = 1'b0;
    tick();
    check("gap_val_a_fall", 32'(in_val), 32'd0);
    in_rdy = 1'b1;
    n = 0;
    while (!in_val && n < 40) begin
      tick();
      n++;
    end
`ifdef IO_TAPE_PACE_EN
    expected_gap = 9;
`else
    expected_gap = 2;
`endif
    check("gap_cycles", 32'(n), 32'(expected_gap));
    check("gap_data_b", 32'(in_data), 32'b00010);
    in_rdy = 1'b0;
    tick();
    check("gap_count0", 32'(rcount), 32'd0);
    idle(12);

    // Punch two codes with host not popping
    offer_punch(5'b11110);
    offer_punch(5'b10101);
    check("pu_count2", 32'(pcount),     32'd2);
    check("pu_valid",  32'(pout_valid), 32'd1);
    check("pu_head",   32'(pout_data),  32'b11110);
    pout_ready = 1'b1;
    tick();
    check("pu_pop1_head",  32'(pout_data), 32'b10101);
    check("pu_pop1_count", 32'(pcount),    32'd1);
    tick();
    pout_ready = 1'b0;
    check("pu_pop2_count", 32'(pcount),     32'd0);
    check("pu_pop2_valid", 32'(pout_valid), 32'd0);

    // Fill punch FIFO, 17th code waits for a host pop
    for (int i = 0; i < 16; i++) offer_punch(5'(i + 1));
    check("pu_full_count", 32'(pcount), 32'd16);
    out_data = 5'h1f;
    out_rdy  = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_ack) seen = 1'b1;
    end
    check("pu_full_hold", 32'(seen), 32'd0);
    pout_ready = 1'b1;
    tick();
    pout_ready = 1'b0;
    check("pu_pop_ack",   32'(out_ack),   32'd0);
    check("pu_pop_count", 32'(pcount),    32'd15);
    check("pu_pop_head",  32'(pout_data), 32'd2);
    tick();
    check("pu_late_ack",   32'(out_ack), 32'd1);
    check("pu_late_count", 32'(pcount),  32'd16);
    out_rdy = 1'b0;
    tick();
    idle(12);

    // Reset mid-handshake with 3 reader entries
    push_reader(5'b01010);
    push_reader(5'b01011);
    push_reader(5'b01100);
    in_rdy = 1'b1;
    tick();
    check("rst_mid_val",    32'(in_val), 32'd1);
    check("rst_mid_count3", 32'(rcount), 32'd3);
    resetn = 1'b0;
    tick();
    check("rst_mid_val0",   32'(in_val),    32'd0);
    check("rst_mid_rcount", 32'(rcount),    32'd0);
    check("rst_mid_tready", 32'(tin_ready), 32'd1);
    check("rst_mid_pcount", 32'(pcount),    32'd0);
    check("rst_mid_idata",  32'(in_data),   32'd0);
    resetn = 1'b1;
    in_rdy = 1'b0;
    tick();

    // Reader FIFO full boundary
    tin_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tin_data = 5'(i + 3);
      tick();
    end
    check("rd_full_ready", 32'(tin_ready), 32'd0);
    check("rd_full_count", 32'(rcount),    32'd16);
    tin_data = 5'h1f;
    tick();
    tin_valid = 1'b0;
    check("rd_over_count", 32'(rcount),  32'd16);
    check("rd_over_head",  32'(in_data), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
